// File: rtl/prbs_checker_if.sv
// prbs_checker_if: serial PRBS receive bundle between a link/loopback
// source and the PRBS checker.
//   clr        source -> checker  synchronous clear of the error counter
//   din_valid  source -> checker  din is meaningful this cycle
//   din        source -> checker  received serial PRBS bit
//   locked     checker -> source  high while the checker is locked
//   err_pulse  checker -> source  one-cycle pulse per detected bit error
//   err_cnt    checker -> source  saturating error count
//   state      checker -> source  FSM state (00 HUNT, 01 SYNC, 10 LOCKED)
interface prbs_checker_if #(
  parameter int CNT_W = 16
);
  logic             clr;
  logic             din_valid;
  logic             din;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_cnt;
  logic [1:0]       state;

  modport master (
    output clr, din_valid, din,
    input  locked, err_pulse, err_cnt, state
  );

  modport slave (
    input  clr, din_valid, din,
    output locked, err_pulse, err_cnt, state
  );
endinterface

// File: rtl/prbs_checker.sv
// prbs_checker: receive-side checker for the 9-bit LFSR pattern generator.
// Self-synchronises to the incoming bit stream (HUNT -> SYNC -> LOCKED),
// then compares each received bit against a free-running local reference
// and counts bit errors. Lock is dropped when too many errors land inside
// one observation window.
// Ports:
//   clk    in  clock, rising edge
//   rst_b  in  asynchronous active-low reset
//   bus    slave side of prbs_checker_if (clr, din_valid, din in;
//          locked, err_pulse, err_cnt, state out, all registered)
module prbs_checker #(
  parameter int LOCK_CNT  = 16,
  parameter int WINDOW    = 64,
  parameter int LOSS_ERRS = 4,
  parameter int CNT_W     = 16
) (
  input  logic           clk,
  input  logic           rst_b,
  prbs_checker_if.slave  bus
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(LOSS_ERRS + 1);

  localparam logic [3:0]    FILL_V = 4'd9;
  localparam logic [MW-1:0] LOCK_V = MW'(LOCK_CNT);
  localparam logic [WW-1:0] WIN_V  = WW'(WINDOW);
  localparam logic [EW-1:0] LOSS_V = EW'(LOSS_ERRS);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    SYNC   = 2'b01,
    LOCKED = 2'b10
  } state_t;

  // Next-bit prediction; taps must stay identical to the generator.
  function automatic logic prbs_pred(input logic [8:0] h);
    return h[8] ^ h[6] ^ h[5] ^ h[3] ^ h[2] ^ h[0];
  endfunction

  state_t           state_r, state_n;
  logic [8:0]       hist_r, hist_n;
  logic [3:0]       fill_cnt_r, fill_cnt_n;
  logic [MW-1:0]    match_cnt_r, match_cnt_n;
  logic [WW-1:0]    win_bits_r, win_bits_n;
  logic [EW-1:0]    win_errs_r, win_errs_n;
  logic             locked_r, locked_n;
  logic             err_pulse_r, err_pulse_n;
  logic [CNT_W-1:0] err_cnt_r, err_cnt_n;
  logic             pred_s;
  logic             err_s;

  assign pred_s = prbs_pred(hist_r);

  // Next-state, counter and output computation.
  always_comb begin
    state_n     = state_r;
    hist_n      = hist_r;
    fill_cnt_n  = fill_cnt_r;
    match_cnt_n = match_cnt_r;
    win_bits_n  = win_bits_r;
    win_errs_n  = win_errs_r;
    err_pulse_n = 1'b0;
    err_s       = 1'b0;

    case (state_r)
      HUNT: begin
        if (bus.din_valid) begin
          hist_n = {hist_r[7:0], bus.din};
          if (fill_cnt_r != FILL_V) begin
            fill_cnt_n = fill_cnt_r + 4'd1;
          end else begin
            fill_cnt_n = fill_cnt_r;
          end
          // All-zero history is the LFSR lock-up state: keep hunting.
          if ((fill_cnt_n == FILL_V) && (hist_n != 9'd0)) begin
            state_n     = SYNC;
            match_cnt_n = {MW{1'b0}};
          end else begin
            state_n = HUNT;
          end
        end else begin
          state_n = HUNT;
        end
      end

      SYNC: begin
        if (bus.din_valid) begin
          hist_n = {hist_r[7:0], bus.din};
          if (hist_n == 9'd0) begin
            state_n     = HUNT;
            fill_cnt_n  = 4'd0;
            match_cnt_n = {MW{1'b0}};
          end else if (bus.din == pred_s) begin
            if ((match_cnt_r + {{(MW-1){1'b0}}, 1'b1}) == LOCK_V) begin
              state_n     = LOCKED;
              match_cnt_n = {MW{1'b0}};
              win_bits_n  = {WW{1'b0}};
              win_errs_n  = {EW{1'b0}};
            end else begin
              match_cnt_n = match_cnt_r + {{(MW-1){1'b0}}, 1'b1};
            end
          end else begin
            // History still holds real received bits, so just restart the run.
            match_cnt_n = {MW{1'b0}};
          end
        end else begin
          state_n = SYNC;
        end
      end

      LOCKED: begin
        if (bus.din_valid) begin
          // Reference free-runs on its own prediction so a single flipped
          // input bit is counted once rather than poisoning later predictions.
          hist_n      = {hist_r[7:0], pred_s};
          err_s       = bus.din ^ pred_s;
          err_pulse_n = err_s;
          win_errs_n  = win_errs_r + {{(EW-1){1'b0}}, err_s};
          win_bits_n  = win_bits_r + {{(WW-1){1'b0}}, 1'b1};
          // Loss check first: an error on the last window bit belongs to that window.
          if (win_errs_n == LOSS_V) begin
            state_n     = HUNT;
            hist_n      = 9'd0;
            fill_cnt_n  = 4'd0;
            match_cnt_n = {MW{1'b0}};
            win_bits_n  = {WW{1'b0}};
            win_errs_n  = {EW{1'b0}};
          end else if (win_bits_n == WIN_V) begin
            win_bits_n = {WW{1'b0}};
            win_errs_n = {EW{1'b0}};
          end else begin
            state_n = LOCKED;
          end
        end else begin
          state_n = LOCKED;
        end
      end

      default: begin
        state_n     = HUNT;
        hist_n      = 9'd0;
        fill_cnt_n  = 4'd0;
        match_cnt_n = {MW{1'b0}};
        win_bits_n  = {WW{1'b0}};
        win_errs_n  = {EW{1'b0}};
      end
    endcase

    // clr has priority over a same-cycle increment; the pulse still fires.
    if (bus.clr) begin
      err_cnt_n = {CNT_W{1'b0}};
    end else if (err_s && !(&err_cnt_r)) begin
      err_cnt_n = err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_n = err_cnt_r;
    end

    locked_n = (state_n == LOCKED);
  end

  // State, history, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r     <= HUNT;
      hist_r      <= 9'd0;
      fill_cnt_r  <= 4'd0;
      match_cnt_r <= {MW{1'b0}};
      win_bits_r  <= {WW{1'b0}};
      win_errs_r  <= {EW{1'b0}};
      locked_r    <= 1'b0;
      err_pulse_r <= 1'b0;
      err_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_n;
      hist_r      <= hist_n;
      fill_cnt_r  <= fill_cnt_n;
      match_cnt_r <= match_cnt_n;
      win_bits_r  <= win_bits_n;
      win_errs_r  <= win_errs_n;
      locked_r    <= locked_n;
      err_pulse_r <= err_pulse_n;
      err_cnt_r   <= err_cnt_n;
    end
  end

  assign bus.state     = state_r;
  assign bus.locked    = locked_r;
  assign bus.err_pulse = err_pulse_r;
  assign bus.err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed, table-driven bench for prbs_checker. A local
// copy of the 9-bit generator supplies the stream; selected bits are
// inverted and the expected state/lock/count/pulse values are written by hand.
module tb_prbs_checker;

  logic clk;
  logic rst_b;

  prbs_checker_if #(.CNT_W(16)) bus ();

  prbs_checker #(
    .LOCK_CNT  (16),
    .WINDOW    (64),
    .LOSS_ERRS (4),
    .CNT_W     (16)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [8:0] SEED = 9'h001;
  localparam logic [1:0] S_HUNT = 2'b00;
  localparam logic [1:0] S_SYNC = 2'b01;
  localparam logic [1:0] S_LOCK = 2'b10;

  typedef struct {
    bit         rst;
    int         n;
    bit         zero;
    bit         flip;
    string      name;
    logic [1:0] st;
    logic       lk;
    int         cnt;
    logic       pl;
  } seg_t;

  seg_t       tbl[$];
  logic [8:0] gen;
  int         total;
  int         bad;

  task automatic add(input bit rst, input int n, input bit zero, input bit flip,
                     input string name, input logic [1:0] st, input logic lk,
                     input int cnt, input logic pl);
    seg_t s;
    s.rst = rst; s.n = n; s.zero = zero; s.flip = flip; s.name = name;
    s.st = st; s.lk = lk; s.cnt = cnt; s.pl = pl;
    tbl.push_back(s);
  endtask

  task automatic check(input string nm, input logic [1:0] st, input logic lk,
                       input int cnt, input logic pl);
    total++;
    if (bus.state !== st) begin
      bad++;
      $display("FAIL %s state got=%b want=%b", nm, bus.state, st);
    end
    total++;
    if (bus.locked !== lk) begin
      bad++;
      $display("FAIL %s locked got=%b want=%b", nm, bus.locked, lk);
    end
    total++;
    if (bus.err_cnt !== cnt[15:0]) begin
      bad++;
      $display("FAIL %s err_cnt got=%0d want=%0d", nm, bus.err_cnt, cnt);
    end
    total++;
    if (bus.err_pulse !== pl) begin
      bad++;
      $display("FAIL %s err_pulse got=%b want=%b", nm, bus.err_pulse, pl);
    end
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    bus.din_valid = 1'b0;
    bus.din = 1'b0;
    bus.clr = 1'b0;
    gen = SEED;
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  // One cycle of stimulus; the generator advances only on valid cycles.
  task automatic send(input bit valid, input bit zero, input bit flip, input bit clr_in);
    logic nb;
    if (valid) begin
      nb  = gen[8] ^ gen[6] ^ gen[5] ^ gen[3] ^ gen[2] ^ gen[0];
      gen = {gen[7:0], nb};
      bus.din = zero ? 1'b0 : (nb ^ flip);
    end else begin
      bus.din = 1'b1;
    end
    bus.din_valid = valid;
    bus.clr = clr_in;
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    bus.clr = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    gen = SEED;
    rst_b = 1'b0;
    bus.din_valid = 1'b0;
    bus.din = 1'b0;
    bus.clr = 1'b0;
    #12;
    check("reset", S_HUNT, 1'b0, 0, 1'b0);

    // Clean stream: acquire and hold lock, then a single error.
    add(1,   8, 0, 0, "a_fill8",    S_HUNT, 0, 0, 0);
    add(0,   1, 0, 0, "a_bit9",     S_SYNC, 0, 0, 0);
    add(0,  15, 0, 0, "a_bit24",    S_SYNC, 0, 0, 0);
    add(0,   1, 0, 0, "a_bit25",    S_LOCK, 1, 0, 0);
    add(0, 475, 0, 0, "a_bit500",   S_LOCK, 1, 0, 0);
    add(0,   1, 0, 1, "a_err1",     S_LOCK, 1, 1, 1);
    add(0,   1, 0, 0, "a_after",    S_LOCK, 1, 1, 0);
    add(0,  30, 0, 0, "a_quiet",    S_LOCK, 1, 1, 0);
    // 3 errors in window 1, 3 in window 2, then a 4th in window 2.
    add(1,  25, 0, 0, "b_lock",     S_LOCK, 1, 0, 0);
    add(0,   1, 0, 1, "b_e1",       S_LOCK, 1, 1, 1);
    add(0,   1, 0, 1, "b_e2",       S_LOCK, 1, 2, 1);
    add(0,   1, 0, 1, "b_e3",       S_LOCK, 1, 3, 1);
    add(0,  61, 0, 0, "b_win1end",  S_LOCK, 1, 3, 0);
    add(0,   1, 0, 1, "b_e4",       S_LOCK, 1, 4, 1);
    add(0,   1, 0, 1, "b_e5",       S_LOCK, 1, 5, 1);
    add(0,   1, 0, 1, "b_e6",       S_LOCK, 1, 6, 1);
    add(0,  10, 0, 0, "b_hold",     S_LOCK, 1, 6, 0);
    add(0,   1, 0, 1, "b_e7loss",   S_HUNT, 0, 7, 1);
    // 4 errors within one window -> loss, relock, then loss on the window's last bit.
    add(1,  25, 0, 0, "c_lock",     S_LOCK, 1, 0, 0);
    add(0,  10, 0, 1, "c_e1",       S_LOCK, 1, 1, 1);
    add(0,  10, 0, 1, "c_e2",       S_LOCK, 1, 2, 1);
    add(0,  10, 0, 1, "c_e3",       S_LOCK, 1, 3, 1);
    add(0,  10, 0, 1, "c_e4loss",   S_HUNT, 0, 4, 1);
    add(0,   8, 0, 0, "c_refill8",  S_HUNT, 0, 4, 0);
    add(0,   1, 0, 0, "c_refill9",  S_SYNC, 0, 4, 0);
    add(0,  15, 0, 0, "c_sync24",   S_SYNC, 0, 4, 0);
    add(0,   1, 0, 0, "c_relock",   S_LOCK, 1, 4, 0);
    add(0,  61, 0, 1, "c_k61",      S_LOCK, 1, 5, 1);
    add(0,   1, 0, 1, "c_k62",      S_LOCK, 1, 6, 1);
    add(0,   1, 0, 1, "c_k63",      S_LOCK, 1, 7, 1);
    add(0,   1, 0, 1, "c_k64loss",  S_HUNT, 0, 8, 1);
    // All-zero input is never accepted.
    add(1,   9, 1, 0, "d_zero9",    S_HUNT, 0, 0, 0);
    add(0, 200, 1, 0, "d_zero209",  S_HUNT, 0, 0, 0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      for (int j = 0; j < tbl[i].n; j++) begin
        send(1'b1, tbl[i].zero, tbl[i].flip && (j == tbl[i].n - 1), 1'b0);
      end
      check(tbl[i].name, tbl[i].st, tbl[i].lk, tbl[i].cnt, tbl[i].pl);
    end

    // din_valid alternating: lock counts valid bits, not cycles.
    do_reset();
    for (int j = 0; j < 24; j++) begin
      send(1'b0, 1'b0, 1'b0, 1'b0);
      send(1'b1, 1'b0, 1'b0, 1'b0);
    end
    check("e_tog24", S_SYNC, 1'b0, 0, 1'b0);
    send(1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0, 1'b0);
    check("e_tog25", S_LOCK, 1'b1, 0, 1'b0);
    send(1'b1, 1'b0, 1'b1, 1'b0);
    check("e_err", S_LOCK, 1'b1, 1, 1'b1);
    send(1'b0, 1'b0, 1'b0, 1'b0);
    check("e_idle", S_LOCK, 1'b1, 1, 1'b0);
    send(1'b1, 1'b0, 1'b1, 1'b1);
    check("e_clr_err", S_LOCK, 1'b1, 0, 1'b1);
    send(1'b1, 1'b0, 1'b0, 1'b1);
    check("e_clr_only", S_LOCK, 1'b1, 0, 1'b0);
    send(1'b1, 1'b0, 1'b1, 1'b0);
    check("e_err2", S_LOCK, 1'b1, 1, 1'b1);

    // Asynchronous reset while locked, sampled between clock edges.
    #2;
    rst_b = 1'b0;
    #1;
    check("e_async_rst", S_HUNT, 1'b0, 0, 1'b0);
    @(negedge clk);
    rst_b = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
